cdb_arbiter: RTL and testbench

//   Shares the single common data bus (CDB) among N result producers (ALU = src 0, LSB load

---
 rtl/cdb_arbiter_pkg.sv | 21 ++
 rtl/cdb_arbiter_src_fifo.sv | 54 +++++
 rtl/cdb_arbiter.sv | 98 +++++++++
 tb/tb_cdb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, source ids and helpers for the CDB arbiter slice.
package cdb_arbiter_pkg;
    localparam int N_SRC_D = 2;
    localparam int DEPTH_D = 4;
    localparam int ROB_W_D = 5;
    localparam int DAT_W_D = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_id_e;

    // Bus entry is packed {cbt, cbr, v, q}, tag in the LSBs.
    function automatic int ent_w(input int rob_w, input int dat_w);
        return rob_w + dat_w + 1 + dat_w;
    endfunction

    function automatic int rr_next(input int p, input int n);
        return (p + 1) % n;
    endfunction
endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// cdb_src_fifo: per-source result FIFO with flush, almost-full flag and drop-on-full.
module cdb_src_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         almost_full,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          wr;

    // A full FIFO refuses the push even when it pops in the same cycle.
    assign wr          = push & (count != CW'(DEPTH));
    assign drop        = push & ~wr;
    assign empty       = count == '0;
    assign almost_full = count >= CW'(DEPTH - 1);
    assign head        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (en && !flush && wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(wr);
                rd_ptr <= rd_ptr + AW'(pop);
                count  <= count + CW'(wr) - CW'(pop);
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of the common data bus among result producers,
// each backed by a small FIFO with same-cycle bypass when empty.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_SRC = N_SRC_D,
    parameter int DEPTH = DEPTH_D,
    parameter int ROB_W = ROB_W_D,
    parameter int DAT_W = DAT_W_D
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   br_flag,
    input  logic [N_SRC-1:0]       src_en_i,
    input  logic [N_SRC*ROB_W-1:0] src_q_i,
    input  logic [N_SRC*DAT_W-1:0] src_v_i,
    input  logic [N_SRC-1:0]       src_cbr_i,
    input  logic [N_SRC*DAT_W-1:0] src_cbt_i,
    output logic [N_SRC-1:0]       src_full_o,
    output logic                   cdb_en_o,
    output logic [ROB_W-1:0]       cdb_q_o,
    output logic [DAT_W-1:0]       cdb_v_o,
    output logic                   cdb_cbr_o,
    output logic [DAT_W-1:0]       cdb_cbt_o,
    output logic                   ovf_o
);
    localparam int EW = ent_w(ROB_W, DAT_W);
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [EW-1:0]    in_ent [N_SRC];
    logic [EW-1:0]    head   [N_SRC];
    logic [N_SRC-1:0] empty, push, pop, drop;
    logic [IW-1:0]    rr_ptr, sel, idx;
    logic             gnt;
    logic [EW-1:0]    win;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign in_ent[i] = {src_cbt_i[i*DAT_W +: DAT_W], src_cbr_i[i],
                            src_v_i[i*DAT_W +: DAT_W], src_q_i[i*ROB_W +: ROB_W]};
        // An input only bypasses when its FIFO is empty, so per-source order holds.
        assign push[i] = src_en_i[i] & ~(gnt & (sel == IW'(i)) & empty[i]);
        assign pop[i]  = gnt & (sel == IW'(i)) & ~empty[i];
        cdb_src_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .flush       (br_flag),
            .push        (push[i]),
            .pop         (pop[i]),
            .din         (in_ent[i]),
            .head        (head[i]),
            .empty       (empty[i]),
            .almost_full (src_full_o[i]),
            .drop        (drop[i])
        );
    end

    always_comb begin
        gnt = 1'b0;
        sel = '0;
        idx = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = IW'((int'(rr_ptr) + k) % N_SRC);
            if (!gnt && (!empty[idx] || src_en_i[idx])) begin
                gnt = 1'b1;
                sel = idx;
            end
        end
        win = empty[sel] ? in_ent[sel] : head[sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            cdb_en_o  <= 1'b0;
            cdb_q_o   <= '0;
            cdb_v_o   <= '0;
            cdb_cbr_o <= 1'b0;
            cdb_cbt_o <= '0;
            ovf_o     <= 1'b0;
        end else if (en) begin
            if (br_flag) begin
                cdb_en_o <= 1'b0;
            end else begin
                cdb_en_o <= gnt;
                if (|drop) ovf_o <= 1'b1;
                if (gnt) begin
                    rr_ptr    <= IW'(rr_next(int'(sel), N_SRC));
                    cdb_q_o   <= win[ROB_W-1:0];
                    cdb_v_o   <= win[ROB_W +: DAT_W];
                    cdb_cbr_o <= win[ROB_W+DAT_W];
                    cdb_cbt_o <= win[EW-1 -: DAT_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random traffic against a queue-based bus model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;
    localparam int NS = N_SRC_D;
    localparam int DP = DEPTH_D;
    localparam int RW = ROB_W_D;
    localparam int DW = DAT_W_D;

    typedef struct packed {
        logic [DW-1:0] cbt;
        logic          cbr;
        logic [DW-1:0] v;
        logic [RW-1:0] q;
    } ent_t;

    logic clk = 0, rst = 1, en = 0, br_flag = 0;
    logic [NS-1:0]    src_en = '0, src_cbr = '0, src_full;
    logic [NS*RW-1:0] src_q = '0;
    logic [NS*DW-1:0] src_v = '0, src_cbt = '0;
    logic             cdb_en_o, cdb_cbr_o, ovf_o;
    logic [RW-1:0]    cdb_q_o;
    logic [DW-1:0]    cdb_v_o, cdb_cbt_o;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .br_flag    (br_flag),
        .src_en_i   (src_en),
        .src_q_i    (src_q),
        .src_v_i    (src_v),
        .src_cbr_i  (src_cbr),
        .src_cbt_i  (src_cbt),
        .src_full_o (src_full),
        .cdb_en_o   (cdb_en_o),
        .cdb_q_o    (cdb_q_o),
        .cdb_v_o    (cdb_v_o),
        .cdb_cbr_o  (cdb_cbr_o),
        .cdb_cbt_o  (cdb_cbt_o),
        .ovf_o      (ovf_o)
    );

    int   checks = 0, fails = 0;
    ent_t fq [NS][$];
    ent_t m_e;
    logic m_en, m_ovf;
    int   rr;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        chk("cdb_en", 80'(cdb_en_o), 80'(m_en));
        chk("cdb_q", 80'(cdb_q_o), 80'(m_e.q));
        chk("cdb_v", 80'(cdb_v_o), 80'(m_e.v));
        chk("cdb_cbr", 80'(cdb_cbr_o), 80'(m_e.cbr));
        chk("cdb_cbt", 80'(cdb_cbt_o), 80'(m_e.cbt));
        for (int i = 0; i < NS; i++)
            chk($sformatf("src_full%0d", i), 80'(src_full[i]), 80'(fq[i].size() >= DP - 1));
        chk("ovf", 80'(ovf_o), 80'(m_ovf));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) fq[i].delete();
        m_e   = '0;
        m_en  = 1'b0;
        m_ovf = 1'b0;
        rr    = 0;
    endtask

    task automatic drive(input logic e, input logic b, input logic [NS-1:0] ens);
        en      = e;
        br_flag = b;
        src_en  = ens;
        for (int i = 0; i < NS; i++) begin
            src_q[i*RW +: RW]   = RW'($urandom);
            src_v[i*DW +: DW]   = $urandom;
            src_cbt[i*DW +: DW] = $urandom;
            src_cbr[i]          = (i == 0) ? 1'($urandom) : 1'b0;
        end
    endtask

    // Model: one queue per source; a scan from rr picks the oldest pending result.
    task automatic tick();
        ent_t in_e [NS];
        int   pre  [NS];
        bit   used [NS];
        bit   g;
        int   gi;
        @(posedge clk);
        for (int i = 0; i < NS; i++) begin
            in_e[i] = {src_cbt[i*DW +: DW], src_cbr[i], src_v[i*DW +: DW], src_q[i*RW +: RW]};
            pre[i]  = fq[i].size();
            used[i] = 1'b0;
        end
        if (en) begin
            if (br_flag) begin
                for (int i = 0; i < NS; i++) fq[i].delete();
                m_en = 1'b0;
            end else begin
                g  = 1'b0;
                gi = 0;
                for (int k = 0; k < NS; k++) begin
                    int i = (rr + k) % NS;
                    if (!g && (pre[i] > 0 || src_en[i])) begin
                        g  = 1'b1;
                        gi = i;
                    end
                end
                if (g) begin
                    if (pre[gi] > 0) m_e = fq[gi].pop_front();
                    else begin
                        m_e      = in_e[gi];
                        used[gi] = 1'b1;
                    end
                    rr = (gi + 1) % NS;
                end
                m_en = g;
                for (int i = 0; i < NS; i++)
                    if (src_en[i] && !used[i]) begin
                        if (pre[i] == DP) m_ovf = 1'b1;
                        else fq[i].push_back(in_e[i]);
                    end
            end
        end
        #1;
        compare();
    endtask

    initial begin
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        compare();
        rst = 0;

        drive(1, 0, 2'b01);
        src_q[RW-1:0] = 5'd3;
        src_v[DW-1:0] = 32'h1234;
        tick();
        chk("single_en", 80'(cdb_en_o), 80'(1));
        chk("single_q", 80'(cdb_q_o), 80'(3));
        chk("single_v", 80'(cdb_v_o), 80'(32'h1234));
        drive(1, 0, 2'b00);
        tick();
        chk("single_once", 80'(cdb_en_o), 80'(0));
        drive(1, 0, 2'b10);
        tick();
        drive(1, 0, 2'b00);
        tick();

        drive(1, 0, 2'b11);
        src_q[RW-1:0]    = 5'd1;
        src_q[2*RW-1:RW] = 5'd2;
        tick();
        chk("cont_first", 80'(cdb_q_o), 80'(1));
        drive(1, 0, 2'b00);
        tick();
        chk("cont_second", 80'(cdb_q_o), 80'(2));
        chk("cont_second_en", 80'(cdb_en_o), 80'(1));
        drive(1, 0, 2'b00);
        tick();

        for (int c = 1; c <= 12; c++) begin
            drive(1, 0, 2'b11);
            tick();
            if (c == 5) chk("fill_lsb_full", 80'(src_full[1]), 80'(1));
            if (c == 5) chk("fill_no_ovf", 80'(ovf_o), 80'(0));
        end
        chk("fill_ovf", 80'(ovf_o), 80'(1));

        drive(1, 1, 2'b11);
        tick();
        chk("flush_en", 80'(cdb_en_o), 80'(0));
        chk("flush_full", 80'(src_full), 80'(0));
        drive(1, 0, 2'b00);
        tick();
        chk("flush_drained", 80'(cdb_en_o), 80'(0));

        repeat (4) begin
            drive(1, 0, 2'b11);
            tick();
        end
        repeat (3) begin
            drive(0, 1'($urandom), NS'($urandom));
            tick();
        end
        repeat (8) begin
            drive(1, 0, 2'b00);
            tick();
        end

        repeat (400) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, NS'($urandom));
            tick();
        end

        drive(1, 0, 2'b11);
        tick();
        drive(1, 0, 2'b11);
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();
        compare();
        rst = 0;

        repeat (60) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, NS'($urandom));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
